// File: rtl/fetch_pkg.sv
// Shared definitions for the IF-stage fetch controller: FSM encodings,
// architectural constants and small PC helpers.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h00000013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h00000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_e;

    // Targets from EX may carry low bits; fetch is always word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~32'd3;
    endfunction

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register that catches a response accepted
// while decode is stalled.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    logic            valid_d, valid_q;
    logic [XLEN-1:0] instr_d, instr_q;
    logic [XLEN-1:0] pc_d,    pc_q;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    // Only the occupancy flag needs a reset; payload is qualified by it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        instr_q <= instr_d;
        pc_q    <= pc_d;
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: owns PCF, runs the instruction-memory valid/ready
// handshake, applies EX redirects and hazard stalls, and drives IF/ID.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    fetch_state_e state_d, state_q;
    logic [XLEN-1:0] pcf_d, pcf_q;
    logic [XLEN-1:0] pend_d, pend_q;
    logic [XLEN-1:0] instr_d, instr_q;
    logic [XLEN-1:0] pcd_d, pcd_q;
    logic [XLEN-1:0] pcp4_d, pcp4_q;
    logic            validd_d, validd_q;

    logic            accept;
    logic            flush;
    logic [XLEN-1:0] target;
    logic            skid_load, skid_unload, skid_clear;
    logic            skid_valid;
    logic [XLEN-1:0] skid_instr, skid_pc;

    // The request is a pure function of state, so it cannot change while
    // a handshake is pending; PCF only moves on accept or outside FETCH/DRAIN.
    assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr = pcf_q;
    assign accept    = imem_req && imem_ready;
    assign target    = align_pc(PCTargetE);

    fetch_skid_buffer u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .unload   (skid_unload),
        .clear    (skid_clear),
        .instr_in (imem_rdata),
        .pc_in    (pcf_q),
        .valid    (skid_valid),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    always_comb begin
        state_d     = state_q;
        pcf_d       = pcf_q;
        pend_d      = pend_q;
        instr_d     = instr_q;
        pcd_d       = pcd_q;
        pcp4_d      = pcp4_q;
        validd_d    = validd_q;
        flush       = PCSrcE;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = PCSrcE;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (PCSrcE) begin
                    pcf_d = target;
                end
            end
            FETCH: begin
                if (PCSrcE) begin
                    // A response arriving with the redirect is wrong-path.
                    if (accept) begin
                        pcf_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = DRAIN;
                    end
                end else if (accept) begin
                    pcf_d = pc_plus4(pcf_q);
                    if (StallF) begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        instr_d  = imem_rdata;
                        pcd_d    = pcf_q;
                        pcp4_d   = pc_plus4(pcf_q);
                        validd_d = 1'b1;
                    end
                end else if (!StallF) begin
                    flush = 1'b1;
                end
            end
            DRAIN: begin
                flush = 1'b1;
                if (PCSrcE) begin
                    pend_d = target;
                end
                if (accept) begin
                    pcf_d   = PCSrcE ? target : pend_q;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pcf_d   = target;
                    state_d = FETCH;
                end else if (!StallF) begin
                    skid_unload = 1'b1;
                    instr_d     = skid_instr;
                    pcd_d       = skid_pc;
                    pcp4_d      = pc_plus4(skid_pc);
                    validd_d    = skid_valid;
                    state_d     = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            validd_d = 1'b0;
            instr_d  = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pcf_q    <= RESET_PC;
            pend_q   <= '0;
            instr_q  <= NOP_INSTR;
            pcd_q    <= '0;
            pcp4_q   <= '0;
            validd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcf_q    <= pcf_d;
            pend_q   <= pend_d;
            instr_q  <= instr_d;
            pcd_q    <= pcd_d;
            pcp4_q   <= pcp4_d;
            validd_q <= validd_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = validd_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboarded bench for fetch_controller: tasks push expected IF/ID contents
// when an accept is driven; a negedge monitor pops and compares deliveries.
module tb_fetch_controller;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] MAGIC = 32'h13570000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic        StallF = 1'b0;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];
    logic [31:0] last_pc = 32'h0;
    logic [31:0] last_instr = 32'h0;
    logic [31:0] exp_pc = 32'h0;
    logic        rst_at_edge = 1'b1;
    logic        stall_at_edge = 1'b0;
    logic        src_at_edge = 1'b0;

    fetch_controller dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .StallF     (StallF),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    // Memory returns a word derived from the address so instr and pc differ.
    assign imem_rdata = imem_addr ^ MAGIC;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rst_at_edge   = rst;
        stall_at_edge = StallF;
        src_at_edge   = PCSrcE;
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_at_edge) begin
            if (src_at_edge) begin
                checks++;
                if (ValidD !== 1'b0 || InstrD !== NOP) begin
                    errors++;
                    $display("FAIL flush: ValidD=%0b InstrD=%h, required ValidD=0 InstrD=%h", ValidD, InstrD, NOP);
                end
            end else if (stall_at_edge) begin
                if (ValidD === 1'b1) begin
                    checks++;
                    if (PCD !== last_pc || InstrD !== last_instr) begin
                        errors++;
                        $display("FAIL stall_hold: PCD=%h InstrD=%h, required PCD=%h InstrD=%h", PCD, InstrD, last_pc, last_instr);
                    end
                end
            end else if (ValidD === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_instr: PCD=%h InstrD=%h, required no valid instruction", PCD, InstrD);
                end else begin
                    e = sb.pop_front();
                    if (InstrD !== e[63:32] || PCD !== e[31:0] || PCPlus4D !== e[31:0] + 32'd4) begin
                        errors++;
                        $display("FAIL deliver: InstrD=%h PCD=%h PCPlus4D=%h, required %h %h %h",
                                 InstrD, PCD, PCPlus4D, e[63:32], e[31:0], e[31:0] + 32'd4);
                    end
                    last_instr = e[63:32];
                    last_pc    = e[31:0];
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        sb.push_back({pc ^ MAGIC, pc});
    endtask

    task automatic reset_dut();
        rst = 1'b1; PCSrcE = 1'b0; StallF = 1'b0; imem_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        sb.delete();
        exp_pc = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h required 0", imem_addr); end
        checks++; if (InstrD !== NOP) begin errors++; $display("FAIL rst_instr: got %h required %h", InstrD, NOP); end
        checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL rst_pcd: got %h required 0", PCD); end
        checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL rst_pcp4: got %h required 0", PCPlus4D); end
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", ValidD); end
        rst = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL first_req: req=%b addr=%h required req=1 addr=0", imem_req, imem_addr);
        end
        exp_pc = 32'h0;
    endtask

    task automatic test_zero_wait();
        logic [31:0] pc = exp_pc;
        imem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== pc) begin
                errors++; $display("FAIL zw_addr: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, pc);
            end
            push(pc);
            pc = pc + 32'd4;
            tick();
            checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL zw_rate: ValidD=%b required 1", ValidD); end
        end
        imem_ready = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL zw_drain: pending=%0d required 0", sb.size()); end
        exp_pc = pc;
    endtask

    task automatic test_latency();
        logic [31:0] pc = exp_pc;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 3; w++) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== pc) begin
                    errors++; $display("FAIL lat_addr: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, pc);
                end
                imem_ready = (w == 2);
                if (w == 2) push(pc);
                tick();
                if (w < 2) begin
                    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL lat_bubble: ValidD=%b required 0", ValidD); end
                end
            end
            pc = pc + 32'd4;
        end
        imem_ready = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL lat_drain: pending=%0d required 0", sb.size()); end
        exp_pc = pc;
    endtask

    task automatic test_stall();
        logic [31:0] pc = exp_pc;
        StallF = 1'b1; imem_ready = 1'b1;
        checks++; if (imem_addr !== pc) begin errors++; $display("FAIL stall_addr: got %h required %h", imem_addr, pc); end
        push(pc);
        pc = pc + 32'd4;
        tick();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b required 0", imem_req); end
            tick();
        end
        StallF = 1'b0;
        tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_release: pending=%0d required 0", sb.size()); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== pc) begin
            errors++; $display("FAIL stall_next: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, pc);
        end
        imem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push(pc);
            pc = pc + 32'd4;
            tick();
        end
        imem_ready = 1'b0;
        checks++; if (imem_addr !== pc || sb.size() != 0) begin
            errors++; $display("FAIL stall_after: addr=%h pending=%0d required addr=%h pending=0", imem_addr, sb.size(), pc);
        end
        exp_pc = pc;
    endtask

    task automatic test_redirect_drain();
        reset_dut();
        imem_ready = 1'b1;
        push(32'h0); tick();
        push(32'h4); tick();
        imem_ready = 1'b0;
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        tick();
        PCSrcE = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || ValidD !== 1'b0) begin
                errors++; $display("FAIL drain_hold: req=%b addr=%h ValidD=%b required 1 00000008 0", imem_req, imem_addr, ValidD);
            end
            imem_ready = (i == 1);
            tick();
        end
        checks++; if (imem_addr !== 32'h100 || ValidD !== 1'b0) begin
            errors++; $display("FAIL drain_target: addr=%h ValidD=%b required 00000100 0", imem_addr, ValidD);
        end
        imem_ready = 1'b1;
        push(32'h100);
        tick();
        imem_ready = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL drain_deliver: pending=%0d required 0", sb.size()); end
        exp_pc = 32'h104;
    endtask

    task automatic test_drain_retarget();
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        tick();
        PCTargetE = 32'h300;
        tick();
        PCSrcE = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            errors++; $display("FAIL retarget_hold: req=%b addr=%h required 1 %h", imem_req, imem_addr, exp_pc);
        end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        checks++; if (imem_addr !== 32'h300) begin errors++; $display("FAIL retarget_overwrite: got %h required 00000300", imem_addr); end
        PCSrcE = 1'b1; PCTargetE = 32'h400;
        tick();
        PCTargetE = 32'h503; imem_ready = 1'b1;
        tick();
        PCSrcE = 1'b0; imem_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h500) begin
            errors++; $display("FAIL retarget_accept: req=%b addr=%h required 1 00000500", imem_req, imem_addr);
        end
        exp_pc = 32'h500;
    endtask

    task automatic test_redirect_accept_stall();
        imem_ready = 1'b1; StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h40;
        tick();
        PCSrcE = 1'b0; StallF = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || ValidD !== 1'b0) begin
            errors++; $display("FAIL redir_stall: req=%b addr=%h ValidD=%b required 1 00000040 0", imem_req, imem_addr, ValidD);
        end
        push(32'h40);
        tick();
        imem_ready = 1'b0;
        checks++; if (imem_addr !== 32'h44 || sb.size() != 0) begin
            errors++; $display("FAIL redir_stall_next: addr=%h pending=%0d required 00000044 0", imem_addr, sb.size());
        end
        exp_pc = 32'h44;
    endtask

    task automatic test_wrap();
        imem_ready = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'hFFFFFFFE;
        tick();
        PCSrcE = 1'b0;
        checks++; if (imem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_align: got %h required fffffffc", imem_addr); end
        push(32'hFFFFFFFC);
        tick();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h required 00000000", imem_addr); end
        checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL wrap_pcp4: got %h required 00000000", PCPlus4D); end
        push(32'h0);
        tick();
        imem_ready = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_drain: pending=%0d required 0", sb.size()); end
        exp_pc = 32'h4;
    endtask

    task automatic test_reset_in_drain();
        imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h300;
        tick();
        PCSrcE = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            errors++; $display("FAIL rd_drain: req=%b addr=%h required 1 %h", imem_req, imem_addr, exp_pc);
        end
        rst = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || ValidD !== 1'b0) begin
            errors++; $display("FAIL rd_ctrl: req=%b addr=%h ValidD=%b required 0 00000000 0", imem_req, imem_addr, ValidD);
        end
        checks++; if (InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0) begin
            errors++; $display("FAIL rd_ifid: InstrD=%h PCD=%h PCPlus4D=%h required %h 0 0", InstrD, PCD, PCPlus4D, NOP);
        end
        rst = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL rd_restart: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        end
        imem_ready = 1'b1;
        push(32'h0);
        tick();
        imem_ready = 1'b0;
        checks++; if (imem_addr !== 32'h4 || sb.size() != 0) begin
            errors++; $display("FAIL rd_after: addr=%h pending=%0d required 00000004 0", imem_addr, sb.size());
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_redirect_drain();
        test_drain_retarget();
        test_redirect_accept_stall();
        test_wrap();
        test_reset_in_drain();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
